// File: rtl/frame_rate_decoder.sv
// -----------------------------------------------------------------------------
// frame_rate_decoder
//
// Receive-side monitor for the animation speed encoder. It watches the LED
// frame bus, measures the number of clk cycles between frame changes, and
// decodes that period back into the 2-bit speed mode that produced it. A
// frame bus that stops changing for TIMEOUT cycles is flagged as stalled.
//
// Ports
//   clk           in   1      system clock
//   rst           in   1      asynchronous, active-high reset
//   led           in   16     observed LED frame, synchronous to clk
//   sw_state      out  2      decoded speed mode, holds its last locked value
//   mode_valid    out  1      1 while the decoder is locked onto a mode
//   stalled       out  1      1 after TIMEOUT cycles without a frame change
//   frame_period  out  CNT_W  last measured frame period in cycles
//   frame_tick    out  1      one-cycle pulse per detected frame change
// -----------------------------------------------------------------------------
module frame_rate_decoder #(
    parameter int CNT_W     = 27,
    parameter int TM0       = 50_000_000,
    parameter int TM1       = 25_000_000,
    parameter int TM2       = 12_500_000,
    parameter int TM3       = 6_250_000,
    parameter int TOL_SHIFT = 3,
    parameter int LOCK_CNT  = 2,
    parameter int TIMEOUT   = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      led,
    output logic [1:0]       sw_state,
    output logic             mode_valid,
    output logic             stalled,
    output logic [CNT_W-1:0] frame_period,
    output logic             frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_MEASURE,
        S_LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LOCK_N     = 4'(LOCK_CNT);

    // Acceptance windows, one bit wider than the counter so the upper bound
    // of the slowest mode cannot wrap.
    localparam logic [CNT_W:0] LO0 = (CNT_W + 1)'(TM0 - (TM0 >> TOL_SHIFT));
    localparam logic [CNT_W:0] HI0 = (CNT_W + 1)'(TM0 + (TM0 >> TOL_SHIFT));
    localparam logic [CNT_W:0] LO1 = (CNT_W + 1)'(TM1 - (TM1 >> TOL_SHIFT));
    localparam logic [CNT_W:0] HI1 = (CNT_W + 1)'(TM1 + (TM1 >> TOL_SHIFT));
    localparam logic [CNT_W:0] LO2 = (CNT_W + 1)'(TM2 - (TM2 >> TOL_SHIFT));
    localparam logic [CNT_W:0] HI2 = (CNT_W + 1)'(TM2 + (TM2 >> TOL_SHIFT));
    localparam logic [CNT_W:0] LO3 = (CNT_W + 1)'(TM3 - (TM3 >> TOL_SHIFT));
    localparam logic [CNT_W:0] HI3 = (CNT_W + 1)'(TM3 + (TM3 >> TOL_SHIFT));

    // State registers
    state_t           state_q,        state_d;
    logic [15:0]      led_q,          led_d;
    logic             primed_q,       primed_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic [1:0]       cand_q,         cand_d;
    logic [3:0]       hits_q,         hits_d;
    logic [1:0]       sw_state_q,     sw_state_d;
    logic             stalled_q,      stalled_d;
    logic [CNT_W-1:0] frame_period_q, frame_period_d;
    logic             frame_tick_q,   frame_tick_d;

    // Combinational helpers
    logic             chg;
    logic [CNT_W-1:0] period;
    logic [CNT_W:0]   period_ext;
    logic             cls_hit;
    logic [1:0]       cls;
    logic [3:0]       hits_inc;
    logic             restart;

    // A change is only meaningful once led_q holds a real sample; the
    // power-up compare against the reset value of led_q is ignored.
    assign chg        = (led != led_q) && primed_q;

    // Period of the frame that ends this cycle; saturates with the counter.
    assign period     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign period_ext = {1'b0, period};
    assign hits_inc   = hits_q + 4'd1;

    // Period classifier: the lowest mode index wins if windows overlap.
    always_comb begin
        cls_hit = 1'b1;
        cls     = 2'd0;
        if (period_ext >= LO0 && period_ext <= HI0) begin
            cls = 2'd0;
        end else if (period_ext >= LO1 && period_ext <= HI1) begin
            cls = 2'd1;
        end else if (period_ext >= LO2 && period_ext <= HI2) begin
            cls = 2'd2;
        end else if (period_ext >= LO3 && period_ext <= HI3) begin
            cls = 2'd3;
        end else begin
            cls_hit = 1'b0;
        end
    end

    // Next-state logic for the datapath and the lock FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        state_d        = state_q;
        led_d          = led;
        primed_d       = 1'b1;
        cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cand_d         = cand_q;
        hits_d         = hits_q;
        sw_state_d     = sw_state_q;
        stalled_d      = stalled_q;
        frame_period_d = frame_period_q;
        frame_tick_d   = chg;
        restart        = 1'b0;

        if (chg) begin
            cnt_d          = '0;
            frame_period_d = period;
            stalled_d      = 1'b0;

            unique case (state_q)
                // First edge after reset or a stall: phase unknown, no period.
                S_IDLE: state_d = S_SYNC;

                S_SYNC: begin
                    if (cls_hit) begin
                        restart = 1'b1;
                    end
                end

                S_MEASURE: begin
                    if (!cls_hit) begin
                        state_d = S_SYNC;
                    end else if (cls == cand_q) begin
                        hits_d = hits_inc;
                        if (hits_inc >= LOCK_N) begin
                            state_d    = S_LOCKED;
                            sw_state_d = cand_q;
                        end
                    end else begin
                        restart = 1'b1;
                    end
                end

                S_LOCKED: begin
                    if (!cls_hit) begin
                        state_d = S_SYNC;
                    end else if (cls != sw_state_q) begin
                        restart = 1'b1;
                    end
                end

                default: state_d = S_IDLE;
            endcase

            // Start a new candidate from this period; with a one-period lock
            // requirement the candidate is accepted immediately.
            if (restart) begin
                if (LOCK_N <= 4'd1) begin
                    state_d    = S_LOCKED;
                    sw_state_d = cls;
                    hits_d     = 4'd1;
                end else begin
                    state_d = S_MEASURE;
                    cand_d  = cls;
                    hits_d  = 4'd1;
                end
            end
        end else if (cnt_q == TIMEOUT_M1) begin
            // Fires once: the counter moves past TIMEOUT-1 afterwards.
            stalled_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            led_q          <= '0;
            primed_q       <= 1'b0;
            cnt_q          <= '0;
            cand_q         <= 2'd0;
            hits_q         <= 4'd0;
            sw_state_q     <= 2'd0;
            stalled_q      <= 1'b0;
            frame_period_q <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            led_q          <= led_d;
            primed_q       <= primed_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            hits_q         <= hits_d;
            sw_state_q     <= sw_state_d;
            stalled_q      <= stalled_d;
            frame_period_q <= frame_period_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign sw_state     = sw_state_q;
    assign mode_valid   = (state_q == S_LOCKED);
    assign stalled      = stalled_q;
    assign frame_period = frame_period_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_frame_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_frame_rate_decoder
//
// Directed bench for frame_rate_decoder with small timing parameters
// (TM0=64 TM1=32 TM2=16 TM3=8, tolerance >>2, lock after 2 periods,
// TIMEOUT=160). Inputs change on the falling edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_rate_decoder;

    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic [15:0]   led;
    logic [1:0]    sw_state;
    logic          mode_valid;
    logic          stalled;
    logic [CW-1:0] frame_period;
    logic          frame_tick;

    int errors = 0;
    int checks = 0;

    frame_rate_decoder #(
        .CNT_W     (CW),
        .TM0       (64),
        .TM1       (32),
        .TM2       (16),
        .TM3       (8),
        .TOL_SHIFT (2),
        .LOCK_CNT  (2),
        .TIMEOUT   (160)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .led          (led),
        .sw_state     (sw_state),
        .mode_valid   (mode_valid),
        .stalled      (stalled),
        .frame_period (frame_period),
        .frame_tick   (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toggle led so that it is 'gap' cycles after the previous toggle made by
    // this task, then stop at the falling edge right after the change is
    // registered (frame_tick and frame_period visible).
    task automatic do_edge(input int gap);
        repeat (gap - 1) @(negedge clk);
        led = ~led;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic saw_tick;
        logic saw_valid;
        rst = 1'b1;
        led = 16'h0001;
        repeat (3) @(negedge clk);
        checks++; if (sw_state !== 2'd0) begin errors++; $display("FAIL reset_sw_state got=%0d exp=0", sw_state); end
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL reset_mode_valid got=%b exp=0", mode_valid); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled got=%b exp=0", stalled); end
        checks++; if (frame_period !== '0) begin errors++; $display("FAIL reset_frame_period got=%0d exp=0", frame_period); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end

        rst = 1'b0;
        saw_tick  = 1'b0;
        saw_valid = 1'b0;
        repeat (159) begin
            @(negedge clk);
            if (frame_tick === 1'b1) saw_tick = 1'b1;
            if (mode_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early got=%b exp=0 at cycle 159", stalled); end
        @(negedge clk);
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_at_160 got=%b exp=1", stalled); end
        checks++; if (saw_tick !== 1'b0) begin errors++; $display("FAIL powerup_tick got=%b exp=0", saw_tick); end
        checks++; if (saw_valid !== 1'b0 || mode_valid !== 1'b0) begin errors++; $display("FAIL powerup_valid got=%b exp=0", saw_valid | mode_valid); end
    endtask

    task automatic test_lock_mode1;
        do_edge(5);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_clear got=%b exp=0", stalled); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_first got=%b exp=1", frame_tick); end
        do_edge(32);
        checks++; if (frame_period !== 12'd32) begin errors++; $display("FAIL m1_period got=%0d exp=32", frame_period); end
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL m1_measure_valid got=%b exp=0", mode_valid); end
        do_edge(32);
        checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL m1_lock_valid got=%b exp=1", mode_valid); end
        checks++; if (sw_state !== 2'd1) begin errors++; $display("FAIL m1_lock_sw got=%0d exp=1", sw_state); end
        @(negedge clk);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got=%b exp=0", frame_tick); end
        do_edge(31);
        checks++; if (frame_period !== 12'd32 || mode_valid !== 1'b1 || sw_state !== 2'd1) begin
            errors++; $display("FAIL m1_hold got=period %0d valid %b sw %0d exp=32 1 1", frame_period, mode_valid, sw_state);
        end
    endtask

    task automatic test_switch_mode2;
        do_edge(16);
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL m2_drop_valid got=%b exp=0", mode_valid); end
        checks++; if (sw_state !== 2'd1) begin errors++; $display("FAIL m2_keep_sw got=%0d exp=1", sw_state); end
        checks++; if (frame_period !== 12'd16) begin errors++; $display("FAIL m2_period got=%0d exp=16", frame_period); end
        do_edge(16);
        checks++; if (mode_valid !== 1'b1 || sw_state !== 2'd2) begin
            errors++; $display("FAIL m2_relock got=valid %b sw %0d exp=1 2", mode_valid, sw_state);
        end
    endtask

    task automatic test_nomatch_mode3;
        do_edge(8);
        do_edge(8);
        checks++; if (mode_valid !== 1'b1 || sw_state !== 2'd3) begin
            errors++; $display("FAIL m3_lock got=valid %b sw %0d exp=1 3", mode_valid, sw_state);
        end
        // 10 is the upper edge of the mode-3 window
        do_edge(10);
        checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL m3_window_hi got=%b exp=1", mode_valid); end
        // 11 falls between the mode-3 and mode-2 windows
        do_edge(11);
        checks++; if (mode_valid !== 1'b0 || sw_state !== 2'd3 || frame_period !== 12'd11) begin
            errors++; $display("FAIL m3_nomatch got=valid %b sw %0d period %0d exp=0 3 11", mode_valid, sw_state, frame_period);
        end
        do_edge(8);
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL m3_resync_measure got=%b exp=0", mode_valid); end
        do_edge(8);
        checks++; if (mode_valid !== 1'b1 || sw_state !== 2'd3) begin
            errors++; $display("FAIL m3_relock got=valid %b sw %0d exp=1 3", mode_valid, sw_state);
        end
    endtask

    task automatic test_timeout_coincide;
        // A change landing exactly on the timeout cycle wins over the stall.
        do_edge(160);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL coincide_stall got=%b exp=0", stalled); end
        checks++; if (frame_period !== 12'd160 || mode_valid !== 1'b0) begin
            errors++; $display("FAIL coincide_period got=period %0d valid %b exp=160 0", frame_period, mode_valid);
        end
        do_edge(64);
        do_edge(64);
        checks++; if (mode_valid !== 1'b1 || sw_state !== 2'd0 || stalled !== 1'b0) begin
            errors++; $display("FAIL m0_lock got=valid %b sw %0d stalled %b exp=1 0 0", mode_valid, sw_state, stalled);
        end
    endtask

    task automatic test_stall_locked;
        repeat (159) @(negedge clk);
        checks++; if (stalled !== 1'b0 || mode_valid !== 1'b1) begin
            errors++; $display("FAIL lk_stall_early got=stalled %b valid %b exp=0 1", stalled, mode_valid);
        end
        @(negedge clk);
        checks++; if (stalled !== 1'b1 || mode_valid !== 1'b0 || sw_state !== 2'd0) begin
            errors++; $display("FAIL lk_stall got=stalled %b valid %b sw %0d exp=1 0 0", stalled, mode_valid, sw_state);
        end
        do_edge(5);
        checks++; if (stalled !== 1'b0 || frame_tick !== 1'b1 || mode_valid !== 1'b0) begin
            errors++; $display("FAIL lk_unstall got=stalled %b tick %b valid %b exp=0 1 0", stalled, frame_tick, mode_valid);
        end
        do_edge(64);
        checks++; if (mode_valid !== 1'b0 || frame_period !== 12'd64) begin
            errors++; $display("FAIL lk_resync got=valid %b period %0d exp=0 64", mode_valid, frame_period);
        end
        do_edge(64);
        checks++; if (mode_valid !== 1'b1 || sw_state !== 2'd0) begin
            errors++; $display("FAIL lk_relock got=valid %b sw %0d exp=1 0", mode_valid, sw_state);
        end
    endtask

    task automatic test_async_reset;
        logic saw_tick;
        do_edge(16);
        do_edge(16);
        do_edge(8);
        checks++; if (sw_state !== 2'd2 || mode_valid !== 1'b0 || frame_period !== 12'd8 || frame_tick !== 1'b1) begin
            errors++; $display("FAIL pre_reset got=sw %0d valid %b period %0d tick %b exp=2 0 8 1",
                               sw_state, mode_valid, frame_period, frame_tick);
        end
        #2;
        rst = 1'b1;
        led = 16'hA5A5;
        #1;
        checks++; if (sw_state !== 2'd0 || mode_valid !== 1'b0 || stalled !== 1'b0 ||
                      frame_period !== '0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL async_reset got=sw %0d valid %b stalled %b period %0d tick %b exp=all 0",
                               sw_state, mode_valid, stalled, frame_period, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_tick = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (frame_tick === 1'b1) saw_tick = 1'b1;
        end
        checks++; if (saw_tick !== 1'b0) begin errors++; $display("FAIL post_reset_tick got=%b exp=0", saw_tick); end
        do_edge(6);
        checks++; if (frame_tick !== 1'b1 || frame_period !== 12'd10 || mode_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_edge got=tick %b period %0d valid %b exp=1 10 0",
                               frame_tick, frame_period, mode_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        led = '0;
        test_reset();
        test_lock_mode1();
        test_switch_mode2();
        test_nomatch_mode3();
        test_timeout_coincide();
        test_stall_locked();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
